// File: rtl/l1a_smp_tagger.sv
// Re-times the ADC sample stream by one cycle and tags each sample with L1A counters and readout-window overlap info.
// Optional saturating drop counter on ERRCNT is enabled by defining L1A_TAG_ERRCNT_EN.
module l1a_smp_tagger #(
    parameter int NSLOT = 8
) (
    input  logic        CLK,
    input  logic        RST_RESYNC,
    input  logic        L1A,
    input  logic        L1A_MATCH,
    input  logic        L1A_PHASE,
    input  logic [6:0]  SAMP_MAX,
    input  logic [11:0] DIN,
    input  logic        DIN_VLD,
    output logic [11:0] WDATA,
    output logic        WREN,
    output logic [43:0] L1A_SMP_DATA,
    output logic        L1A_WRT_EN,
    output logic        DROP,
    output logic [7:0]  ERRCNT
);

    localparam int IDXW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    // Event counters and the single pending (accepted but not yet started) window.
    logic [23:0]     r_l1acnt;
    logic [11:0]     r_l1amcnt;
    logic            r_pend;
    logic            r_pend_phase;
    logic [6:0]      r_pend_smax;
    logic [23:0]     r_pend_l1acnt;
    logic [11:0]     r_pend_l1amcnt;

    // Each slot holds the number of samples still owed to its window after the current one; 0 means free.
    logic [6:0]      r_slot_cnt [NSLOT];

    logic [11:0]     r_wdata;
    logic            r_wren;
    logic [43:0]     r_tag;
    logic            r_drop;

    logic            w_l1a_match;
    logic            w_consume;
    logic            w_pend_keep;
    logic            w_open;
    logic            w_free_found;
    logic [IDXW-1:0] w_free_idx;
    logic [3:0]      w_active_n;
    logic [3:0]      w_n;
    logic [3:0]      w_ovrlap_cnt;
    logic [6:0]      w_smax_eff;
    logic [23:0]     w_l1acnt_nxt;
    logic [11:0]     w_l1amcnt_nxt;
    logic [43:0]     w_tag;
    logic            w_drop_evt;

    assign w_l1a_match   = L1A & L1A_MATCH;
    assign w_consume     = r_pend & DIN_VLD;
    assign w_pend_keep   = r_pend & ~w_consume;
    assign w_smax_eff    = (SAMP_MAX == 7'd0) ? 7'd1 : SAMP_MAX;
    assign w_l1acnt_nxt  = r_l1acnt + 24'd1;
    assign w_l1amcnt_nxt = r_l1amcnt + 12'd1;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_active_n   = 4'd0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (r_slot_cnt[i] != 7'd0) begin
                w_active_n = w_active_n + 4'd1;
            end else if (!w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = IDXW'(i);
            end
        end
    end

    // A window that finds no free slot at its start sample is lost.
    assign w_open       = w_consume & w_free_found;
    assign w_n          = w_active_n + {3'd0, w_open};
    assign w_ovrlap_cnt = (w_n == 4'd0) ? 4'd0 : w_n - 4'd1;
    assign w_drop_evt   = (w_consume & ~w_free_found) | (w_l1a_match & w_pend_keep);

    assign w_tag = {(w_n >= 4'd3), (w_n >= 4'd2), (w_open & r_pend_phase), w_open, w_ovrlap_cnt,
                    (w_open ? r_pend_l1amcnt : r_l1amcnt), (w_open ? r_pend_l1acnt : r_l1acnt)};

    // NOTE: sequential state is updated with non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge CLK or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            r_l1acnt       <= '0;
            r_l1amcnt      <= '0;
            r_pend         <= 1'b0;
            r_pend_phase   <= 1'b0;
            r_pend_smax    <= '0;
            r_pend_l1acnt  <= '0;
            r_pend_l1amcnt <= '0;
            r_drop         <= 1'b0;
        end else begin
            if (L1A) r_l1acnt <= w_l1acnt_nxt;
            if (w_l1a_match) r_l1amcnt <= w_l1amcnt_nxt;
            if (w_l1a_match && !w_pend_keep) begin
                r_pend         <= 1'b1;
                r_pend_phase   <= L1A_PHASE;
                r_pend_smax    <= w_smax_eff;
                r_pend_l1acnt  <= w_l1acnt_nxt;
                r_pend_l1amcnt <= w_l1amcnt_nxt;
            end else if (w_consume) begin
                r_pend <= 1'b0;
            end
            if (w_drop_evt) r_drop <= 1'b1;
        end
    end

    // NOTE: the slot array is reset, unlike a data RAM, because "free" must be known after a resync.
    always_ff @(posedge CLK or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            for (int i = 0; i < NSLOT; i++) r_slot_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (w_open && (IDXW'(i) == w_free_idx)) begin
                    r_slot_cnt[i] <= r_pend_smax - 7'd1;
                end else if (DIN_VLD && (r_slot_cnt[i] != 7'd0)) begin
                    r_slot_cnt[i] <= r_slot_cnt[i] - 7'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            r_wdata <= '0;
            r_wren  <= 1'b0;
            r_tag   <= '0;
        end else begin
            r_wdata <= DIN;
            r_wren  <= DIN_VLD;
            r_tag   <= w_tag;
        end
    end

`ifdef L1A_TAG_ERRCNT_EN
    logic [7:0] r_errcnt;

    always_ff @(posedge CLK or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            r_errcnt <= '0;
        end else if (w_drop_evt && (r_errcnt != 8'hFF)) begin
            r_errcnt <= r_errcnt + 8'd1;
        end
    end

    assign ERRCNT = r_errcnt;
`else
    assign ERRCNT = 8'd0;
`endif

    assign WDATA        = r_wdata;
    assign WREN         = r_wren;
    assign L1A_SMP_DATA = r_tag;
    assign L1A_WRT_EN   = r_wren;
    assign DROP         = r_drop;

endmodule

// File: tb/tb_l1a_smp_tagger.sv
// Self-checking bench for l1a_smp_tagger: a behavioural window model fills a scoreboard queue as stimulus is driven;
// a negedge monitor pops and compares every written sample. Builds with or without L1A_TAG_ERRCNT_EN.
module tb_l1a_smp_tagger;

    logic        clk;
    logic        rst;
    logic        l1a;
    logic        l1a_match;
    logic        l1a_phase;
    logic [6:0]  samp_max;
    logic [11:0] din;
    logic        din_vld;
    logic [11:0] wdata;
    logic        wren;
    logic [43:0] smp_data;
    logic        wrt_en;
    logic        drop;
    logic [7:0]  errcnt;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard entries are {WDATA, L1A_SMP_DATA}.
    logic [55:0] sb_q[$];

    // Reference model state.
    logic [23:0] m_l1acnt;
    logic [11:0] m_l1amcnt;
    logic        m_pend;
    logic        m_pphase;
    int          m_psmax;
    logic [23:0] m_pa;
    logic [11:0] m_pm;
    int          m_rem[$];
    logic        m_drop;
    int          m_err;

    l1a_smp_tagger #(.NSLOT(8)) dut (
        .CLK          (clk),
        .RST_RESYNC   (rst),
        .L1A          (l1a),
        .L1A_MATCH    (l1a_match),
        .L1A_PHASE    (l1a_phase),
        .SAMP_MAX     (samp_max),
        .DIN          (din),
        .DIN_VLD      (din_vld),
        .WDATA        (wdata),
        .WREN         (wren),
        .L1A_SMP_DATA (smp_data),
        .L1A_WRT_EN   (wrt_en),
        .DROP         (drop),
        .ERRCNT       (errcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [55:0] exp_e;
        n_checks++;
        if (wrt_en !== wren) begin
            n_errors++;
            $display("FAIL wrt_en_eq_wren: L1A_WRT_EN=%b WREN=%b", wrt_en, wren);
        end
        if (wren === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_sample: WDATA=%h TAG=%h with empty scoreboard", wdata, smp_data);
            end else begin
                exp_e = sb_q.pop_front();
                if ({wdata, smp_data} !== exp_e) begin
                    n_errors++;
                    $display("FAIL sample_tag: got WDATA=%h TAG=%h expected WDATA=%h TAG=%h",
                             wdata, smp_data, exp_e[55:44], exp_e[43:0]);
                end
            end
        end
    end

    function automatic int exp_errcnt();
`ifdef L1A_TAG_ERRCNT_EN
        return m_err;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_l1acnt  = '0;
        m_l1amcnt = '0;
        m_pend    = 1'b0;
        m_pphase  = 1'b0;
        m_psmax   = 0;
        m_pa      = '0;
        m_pm      = '0;
        m_rem.delete();
        m_drop    = 1'b0;
        m_err     = 0;
        sb_q.delete();
    endtask

    task automatic model_drop();
        m_drop = 1'b1;
        if (m_err < 255) m_err++;
    endtask

    // Drives one cycle of inputs at the negedge and advances the reference model by that cycle.
    task automatic drive_cycle(input logic a, input logic mt, input logic ph, input logic [6:0] smax,
                               input logic vld, input logic [11:0] d);
        logic       cons;
        logic       opn;
        int         n;
        logic [3:0] oc;
        logic [43:0] tag;
        int         nxt[$];
        @(negedge clk);
        l1a = a; l1a_match = mt; l1a_phase = ph; samp_max = smax; din_vld = vld; din = d;
        cons = 1'b0;
        if (vld) begin
            cons = m_pend;
            n    = m_rem.size();
            opn  = cons && (n < 8);
            if (cons && !opn) model_drop();
            if (opn) n++;
            oc  = (n == 0) ? 4'd0 : 4'(n - 1);
            tag = {(n >= 3), (n >= 2), (opn ? m_pphase : 1'b0), opn, oc,
                   (opn ? m_pm : m_l1amcnt), (opn ? m_pa : m_l1acnt)};
            sb_q.push_back({d, tag});
            foreach (m_rem[i]) if (m_rem[i] > 1) nxt.push_back(m_rem[i] - 1);
            if (opn && (m_psmax > 1)) nxt.push_back(m_psmax - 1);
            m_rem = nxt;
            if (cons) m_pend = 1'b0;
        end
        if (a) begin
            m_l1acnt = m_l1acnt + 24'd1;
            if (mt) begin
                m_l1amcnt = m_l1amcnt + 12'd1;
                if (m_pend) begin
                    model_drop();
                end else begin
                    m_pend   = 1'b1;
                    m_pphase = ph;
                    m_psmax  = (smax == 7'd0) ? 1 : int'(smax);
                    m_pa     = m_l1acnt;
                    m_pm     = m_l1amcnt;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 12'h000);
    endtask

    task automatic do_reset();
        idle(2);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drained: %0d samples never written, expected 0", sb_q.size());
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_drop_err(input string name);
        n_checks++;
        if (drop !== m_drop) begin
            n_errors++;
            $display("FAIL %s_drop: DROP=%b expected %b", name, drop, m_drop);
        end
        n_checks++;
        if (errcnt !== 8'(exp_errcnt())) begin
            n_errors++;
            $display("FAIL %s_errcnt: ERRCNT=%0d expected %0d", name, errcnt, exp_errcnt());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        l1a = 1'b0; l1a_match = 1'b0; l1a_phase = 1'b0; samp_max = 7'd0; din = '0; din_vld = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wdata, wren, smp_data, wrt_en, drop, errcnt} !== 68'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: WDATA=%h WREN=%b TAG=%h WRT_EN=%b DROP=%b ERRCNT=%0d expected all 0",
                     wdata, wren, smp_data, wrt_en, drop, errcnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_window();
        do_reset();
        drive_cycle(1'b1, 1'b1, 1'b1, 7'd8, 1'b0, 12'h000);
        for (int i = 1; i <= 9; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 7'd8, 1'b1, 12'(12'h100 + i));
            if (i == 2) begin
                #1;
                n_checks++;
                if (smp_data !== {4'b0011, 4'd0, 12'd1, 24'd1}) begin
                    n_errors++;
                    $display("FAIL single_first_tag: TAG=%h expected %h", smp_data, {4'b0011, 4'd0, 12'd1, 24'd1});
                end
            end
        end
        idle(1);
        #1;
        n_checks++;
        if ({wren, smp_data} !== {1'b1, 4'b0000, 4'd0, 12'd1, 24'd1}) begin
            n_errors++;
            $display("FAIL single_ninth_untagged: WREN=%b TAG=%h expected WREN=1 TAG=%h",
                     wren, smp_data, {4'b0000, 4'd0, 12'd1, 24'd1});
        end
        check_drop_err("single");
    endtask

    task automatic test_unmatched_then_matched();
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b1, 7'd2, 1'b0, 12'h000);
        drive_cycle(1'b0, 1'b0, 1'b0, 7'd2, 1'b1, 12'h201);
        drive_cycle(1'b1, 1'b1, 1'b0, 7'd2, 1'b0, 12'h000);
        drive_cycle(1'b0, 1'b0, 1'b0, 7'd9, 1'b1, 12'h202);
        drive_cycle(1'b0, 1'b0, 1'b0, 7'd9, 1'b1, 12'h203);
        #1;
        n_checks++;
        if (smp_data !== {4'b0001, 4'd0, 12'd1, 24'd2}) begin
            n_errors++;
            $display("FAIL unmatched_start_tag: TAG=%h expected %h", smp_data, {4'b0001, 4'd0, 12'd1, 24'd2});
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 7'd9, 1'b1, 12'h204);
        check_drop_err("unmatched");
    endtask

    task automatic test_overlap();
        do_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 7'd8, 1'b0, 12'h000);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 7'd8, 1'b1, 12'(12'h300 + i));
        drive_cycle(1'b1, 1'b1, 1'b1, 7'd8, 1'b0, 12'h000);
        for (int i = 3; i < 13; i++) drive_cycle(1'b0, 1'b0, 1'b0, 7'd3, 1'b1, 12'(12'h300 + i));
        check_drop_err("overlap");
    endtask

    task automatic test_slot_overflow();
        do_reset();
        for (int w = 0; w < 9; w++) begin
            drive_cycle(1'b1, 1'b1, w[0], 7'd100, 1'b0, 12'h000);
            drive_cycle(1'b0, 1'b0, 1'b0, 7'd100, 1'b1, 12'(12'h400 + w));
        end
        idle(1);
        check_drop_err("overflow");
    endtask

    task automatic test_double_pending();
        do_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 7'd4, 1'b0, 12'h000);
        idle(1);
        drive_cycle(1'b1, 1'b1, 1'b1, 7'd4, 1'b0, 12'h000);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b0, 7'd4, 1'b1, 12'(12'h500 + i));
        check_drop_err("double");
    endtask

    task automatic test_smax_zero();
        do_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 12'h000);
        drive_cycle(1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 12'h601);
        drive_cycle(1'b1, 1'b1, 1'b0, 7'd2, 1'b1, 12'h602);
        for (int i = 3; i < 6; i++) drive_cycle(1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 12'(12'h600 + i));
        check_drop_err("smax0");
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 7'd20, 1'b0, 12'h000);
        drive_cycle(1'b0, 1'b0, 1'b0, 7'd20, 1'b1, 12'h701);
        drive_cycle(1'b0, 1'b0, 1'b0, 7'd20, 1'b1, 12'h702);
        drive_cycle(1'b1, 1'b1, 1'b0, 7'd20, 1'b0, 12'h000);
        drive_cycle(1'b1, 1'b1, 1'b0, 7'd20, 1'b0, 12'h000);
        drive_cycle(1'b0, 1'b0, 1'b0, 7'd20, 1'b1, 12'h703);
        #1;
        check_drop_err("premid");
        @(negedge clk);
        l1a = 1'b0; l1a_match = 1'b0; din_vld = 1'b1; din = 12'h704;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({wdata, wren, smp_data, wrt_en, drop, errcnt} !== 68'd0) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: WDATA=%h WREN=%b TAG=%h DROP=%b ERRCNT=%0d expected all 0",
                     wdata, wren, smp_data, drop, errcnt);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (wren !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_inflight: WREN=%b expected 0", wren);
        end
        @(negedge clk);
        rst = 1'b0; din_vld = 1'b0;
        drive_cycle(1'b1, 1'b1, 1'b1, 7'd3, 1'b0, 12'h000);
        drive_cycle(1'b0, 1'b0, 1'b0, 7'd3, 1'b1, 12'h705);
        drive_cycle(1'b0, 1'b0, 1'b0, 7'd3, 1'b0, 12'h000);
        #1;
        n_checks++;
        if (smp_data !== {4'b0011, 4'd0, 12'd1, 24'd1}) begin
            n_errors++;
            $display("FAIL post_reset_tag: TAG=%h expected %h", smp_data, {4'b0011, 4'd0, 12'd1, 24'd1});
        end
        check_drop_err("postmid");
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_unmatched_then_matched();
        test_overlap();
        test_slot_overflow();
        test_double_pending();
        test_smax_zero();
        test_reset_mid();
        do_reset();
        idle(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
